// File: rtl/radix2_seq_divider_if.sv
// ----------------------------------------------------------------------------
// radix2_seq_divider_if
//   Handshake and operand/result bundle for the sequential divider.
//   master : requester side (drives start and operands, reads results)
//   slave  : divider side
//   Signals (named from the divider's point of view):
//     i_start, i_dividend, i_divisor, i_sign_mode  -> into the divider
//     o_quotient, o_remainder, o_div_by_zero,
//     o_done, o_busy                               -> out of the divider
// ----------------------------------------------------------------------------
interface radix2_seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic [1:0]       i_sign_mode;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;
    logic             o_done;
    logic             o_busy;

    modport master (
        output i_start, i_dividend, i_divisor, i_sign_mode,
        input  o_quotient, o_remainder, o_div_by_zero, o_done, o_busy
    );

    modport slave (
        input  i_start, i_dividend, i_divisor, i_sign_mode,
        output o_quotient, o_remainder, o_div_by_zero, o_done, o_busy
    );
endinterface

// File: rtl/radix2_seq_divider.sv
// ----------------------------------------------------------------------------
// radix2_seq_divider
//   Sequential restoring radix-2 divider, one quotient bit per clock, fixed
//   latency of WIDTH+2 cycles from the accepting edge to done. Truncates
//   toward zero; the remainder takes the sign of the dividend. Divide by zero
//   returns all-ones quotient, the original dividend as remainder and raises
//   o_div_by_zero.
//   Ports:
//     i_clk  rising-edge clock
//     i_rst  synchronous active-high reset, aborts any division in flight
//     bus    radix2_seq_divider_if.slave (start/operands in, results out)
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; operands latched on the accepting edge
//   PREP   | signs, magnitudes and divide-by-zero flag formed
//   ITER   | WIDTH shift/subtract steps, one quotient bit each
//   FIXUP  | sign correction, results registered, done pulsed
// ----------------------------------------------------------------------------
module radix2_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    radix2_seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP} state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_b;
    logic [1:0]       r_mode;
    logic             r_sa, r_sb, r_dz;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_q;
    // Partial remainder: after each restore it is below |b|, so WIDTH bits
    // suffice; the extra bit only exists in the shifted trial value.
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_quot, r_remo;
    logic             r_dzo, r_done, r_busy;

    logic             w_sa, w_sb;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_sa    = r_mode[1] & r_a[WIDTH-1];
    assign w_sb    = r_mode[0] & r_b[WIDTH-1];
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mag_b});
    // When w_ge holds the true difference is below 2^WIDTH, so the low
    // WIDTH bits of a WIDTH-bit subtraction are exact.
    assign w_sub   = w_shift[WIDTH-1:0] - r_mag_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_next = S_PREP;
            S_PREP:  w_next = S_ITER;
            S_ITER:  if (r_cnt == CW'(1)) w_next = S_FIXUP;
            S_FIXUP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_mag_b <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dzo   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_a    <= bus.i_dividend;
                        r_b    <= bus.i_divisor;
                        r_mode <= bus.i_sign_mode;
                        r_busy <= 1'b1;
                    end
                end
                S_PREP: begin
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_dz    <= (r_b == '0);
                    // Negating -2^(W-1) yields 2^(W-1) as an unsigned magnitude.
                    r_q     <= w_sa ? -r_a : r_a;
                    r_mag_b <= w_sb ? -r_b : r_b;
                    r_rem   <= '0;
                    r_cnt   <= CNT_INIT;
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIXUP: begin
                    if (r_dz) begin
                        r_quot <= '1;
                        r_remo <= r_a;
                        r_dzo  <= 1'b1;
                    end else begin
                        r_quot <= (r_sa ^ r_sb) ? -r_q : r_q;
                        r_remo <= r_sa ? -r_rem : r_rem;
                        r_dzo  <= 1'b0;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_quotient    = r_quot;
    assign bus.o_remainder   = r_remo;
    assign bus.o_div_by_zero = r_dzo;
    assign bus.o_done        = r_done;
    assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_radix2_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_radix2_seq_divider
//   Self-checking bench for radix2_seq_divider (WIDTH=16). Expected results
//   are queued when a start is driven and compared when done pulses.
// ----------------------------------------------------------------------------
module tb_radix2_seq_divider;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];

    radix2_seq_divider_if #(.WIDTH(W)) bus ();

    radix2_seq_divider #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] m);
        exp_t   e;
        longint va, vb;
        if (m[1]) va = longint'($signed(a)); else va = longint'({48'd0, a});
        if (m[0]) vb = longint'($signed(b)); else vb = longint'({48'd0, b});
        e.t = 0;
        if (vb == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = W'(va / vb);
            e.r  = W'(va % vb);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called right after a negedge; waits for the divider to be free, then
    // presents one start for a single cycle and queues the expectation.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] m, input exp_t e_in);
        exp_t e;
        int   w;
        e = e_in;
        w = 0;
        while (bus.o_busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (bus.o_busy) begin
            check("busy_timeout", 32'd1, 32'd0);
            return;
        end
        bus.i_start     = 1'b1;
        bus.i_dividend  = a;
        bus.i_divisor   = b;
        bus.i_sign_mode = m;
        e.t = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        drive_op(a, b, m, model(a, b, m));
    endtask

    task automatic do_div_k(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.t = 0;
        drive_op(a, b, m, e);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    // Result monitor: samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.o_done) begin
                check("done_with_busy", 32'(bus.o_busy), 32'd0);
                check("done_two_cycles", 32'(prev_done), 32'd0);
                if (sb_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("quotient", 32'(bus.o_quotient), 32'(e.q));
                    check("remainder", 32'(bus.o_remainder), 32'(e.r));
                    check("div_by_zero", 32'(bus.o_div_by_zero), 32'(e.dz));
                    // Driven at negedge cyc=n, accepted at edge k=n+1,
                    // done after edge k+W+2, seen at the following negedge.
                    check("latency", 32'(cyc - e.t), 32'(W + 3));
                end
            end
            prev_done = bus.o_done;
        end
    end

    initial begin
        int w;
        bus.i_start     = 1'b0;
        bus.i_dividend  = '0;
        bus.i_divisor   = '0;
        bus.i_sign_mode = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_quotient", 32'(bus.o_quotient), 32'd0);
        check("rst_remainder", 32'(bus.o_remainder), 32'd0);
        check("rst_dz", 32'(bus.o_div_by_zero), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        do_div_k(16'd100, 16'd7, 2'b00, 16'd14, 16'd2, 1'b0);
        do_div_k(-16'sd100, 16'd7, 2'b11, 16'hFFF2, 16'hFFFE, 1'b0);
        do_div_k(16'd100, -16'sd7, 2'b11, 16'hFFF2, 16'h0002, 1'b0);
        do_div_k(16'd1234, 16'd0, 2'b00, 16'hFFFF, 16'd1234, 1'b1);
        do_div_k(16'd1234, 16'd0, 2'b11, 16'hFFFF, 16'd1234, 1'b1);
        do_div_k(16'd50, 16'd5, 2'b11, 16'd10, 16'd0, 1'b0);
        do_div_k(16'h8000, 16'hFFFF, 2'b11, 16'h8000, 16'h0000, 1'b0);
        do_div_k(16'h8000, 16'hFFFF, 2'b00, 16'h0000, 16'h8000, 1'b0);
        do_div_k(16'hFFFF, 16'hFFFF, 2'b01, 16'h0001, 16'h0000, 1'b0);

        // Start pulses while busy must be ignored
        do_div_k(16'd1000, 16'd3, 2'b00, 16'd333, 16'd1, 1'b0);
        repeat (3) @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_dividend  = 16'd77;
        bus.i_divisor   = 16'd0;
        bus.i_sign_mode = 2'b11;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b0;
        // Queued back-to-back with the previous: issued in its done cycle
        do_div_k(16'd9, 16'd4, 2'b00, 16'd2, 16'd1, 1'b0);

        // Reset during ITER aborts the division with no done pulse
        w = 0;
        while (bus.o_busy && w < 100) begin @(negedge clk); w++; end
        do_div(16'd4321, 16'd17, 2'b00);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_quotient", 32'(bus.o_quotient), 32'd0);
        check("abort_remainder", 32'(bus.o_remainder), 32'd0);
        check("abort_dz", 32'(bus.o_div_by_zero), 32'd0);
        check("abort_done", 32'(bus.o_done), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_idle_busy", 32'(bus.o_busy), 32'd0);
        do_div_k(16'd300, 16'd12, 2'b00, 16'd25, 16'd0, 1'b0);

        // Random operands against the truncating reference model
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 400; i++) begin
                do_div(rand_opnd(), rand_opnd(), 2'(m));
            end
        end

        w = 0;
        while (sb_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
        check("drain_queue", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
